// File: rtl/lane_vrf_write_arbiter_if.sv
// Write-port bundle between the VRF write sources, the arbiter and the VRF.
// Latency: none; wiring only.
// Backpressure: req_ready per source and vrfWriteRequest_ready from the VRF.
interface lane_vrf_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_bits_vd;
  logic [2*NUM_REQ-1:0]  req_bits_offset;
  logic [4*NUM_REQ-1:0]  req_bits_mask;
  logic [32*NUM_REQ-1:0] req_bits_data;
  logic [NUM_REQ-1:0]    req_bits_last;
  logic [3*NUM_REQ-1:0]  req_bits_instructionIndex;

  logic                  vrfWriteRequest_ready;
  logic                  vrfWriteRequest_valid;
  logic [4:0]            vrfWriteRequest_bits_vd;
  logic [1:0]            vrfWriteRequest_bits_offset;
  logic [3:0]            vrfWriteRequest_bits_mask;
  logic [31:0]           vrfWriteRequest_bits_data;
  logic                  vrfWriteRequest_bits_last;
  logic [2:0]            vrfWriteRequest_bits_instructionIndex;
  logic [IDX_W-1:0]      grant_idx;

  // Arbiter view.
  modport slave (
    input  req_valid, req_bits_vd, req_bits_offset, req_bits_mask,
           req_bits_data, req_bits_last, req_bits_instructionIndex,
           vrfWriteRequest_ready,
    output req_ready, vrfWriteRequest_valid, vrfWriteRequest_bits_vd,
           vrfWriteRequest_bits_offset, vrfWriteRequest_bits_mask,
           vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
           vrfWriteRequest_bits_instructionIndex, grant_idx
  );

  // Environment view: write sources plus the VRF.
  modport master (
    output req_valid, req_bits_vd, req_bits_offset, req_bits_mask,
           req_bits_data, req_bits_last, req_bits_instructionIndex,
           vrfWriteRequest_ready,
    input  req_ready, vrfWriteRequest_valid, vrfWriteRequest_bits_vd,
           vrfWriteRequest_bits_offset, vrfWriteRequest_bits_mask,
           vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
           vrfWriteRequest_bits_instructionIndex, grant_idx
  );
endinterface

// File: rtl/lane_vrf_write_arbiter.sv
// Round-robin share of the lane's single VRF write port among NUM_REQ sources.
// Latency: exactly one cycle, from the request firing to vrfWriteRequest.
// Backpressure: a 1-entry output stage reloads on drain, so writes stream one per cycle; a stalled VRF holds it and drops req_ready.
module lane_vrf_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input logic                  clock,
  input logic                  reset,
  lane_vrf_write_arbiter_if.slave io
);

  typedef struct packed {
    logic [4:0]  vd;
    logic [1:0]  offset;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic [2:0]  instructionIndex;
  } writeBits_t;

  logic             outValid;
  writeBits_t       outBits;
  logic [IDX_W-1:0] rrPtr;
  logic [IDX_W-1:0] grantIdx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] nextPtr;
  logic [IDX_W:0]   candSum;
  logic             anyValid;
  logic             canLoad;
  logic             fire;
  writeBits_t       winBits;

  // Round-robin search starting at rrPtr; walking downward lets the nearest valid source overwrite farther ones.
  always_comb begin
    winner  = rrPtr;
    candSum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      candSum = {1'b0, rrPtr} + (IDX_W+1)'(k);
      if (candSum >= (IDX_W+1)'(NUM_REQ)) begin
        candSum = candSum - (IDX_W+1)'(NUM_REQ);
      end
      if (io.req_valid[candSum[IDX_W-1:0]]) begin
        winner = candSum[IDX_W-1:0];
      end
    end
  end

  assign anyValid = |io.req_valid;
  // The output stage is a pipeline register: it may load when empty or when its current beat leaves this cycle.
  assign canLoad  = ~outValid | io.vrfWriteRequest_ready;
  // Reset gates the handshake so no source believes a beat was taken during reset.
  assign fire     = canLoad & anyValid & ~reset;
  assign nextPtr  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Grant is one-hot on the winner and only while the output stage can take it.
  always_comb begin
    io.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      io.req_ready[i] = fire & (winner == IDX_W'(i));
    end
  end

  // Select the winning source's fields out of the packed request buses.
  always_comb begin
    winBits                  = '0;
    winBits.vd               = io.req_bits_vd[5*winner +: 5];
    winBits.offset           = io.req_bits_offset[2*winner +: 2];
    winBits.mask             = io.req_bits_mask[4*winner +: 4];
    winBits.data             = io.req_bits_data[32*winner +: 32];
    winBits.last             = io.req_bits_last[winner];
    winBits.instructionIndex = io.req_bits_instructionIndex[3*winner +: 3];
  end

  // Output stage and pointer: load on fire, clear valid on a plain drain, hold everything while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      outValid <= 1'b0;
      outBits  <= '0;
      rrPtr    <= '0;
      grantIdx <= '0;
    end else if (fire) begin
      outValid <= 1'b1;
      outBits  <= winBits;
      rrPtr    <= nextPtr;
      grantIdx <= winner;
    end else if (outValid & io.vrfWriteRequest_ready) begin
      outValid <= 1'b0;
    end
  end

  assign io.vrfWriteRequest_valid                 = outValid;
  assign io.vrfWriteRequest_bits_vd               = outBits.vd;
  assign io.vrfWriteRequest_bits_offset           = outBits.offset;
  assign io.vrfWriteRequest_bits_mask             = outBits.mask;
  assign io.vrfWriteRequest_bits_data             = outBits.data;
  assign io.vrfWriteRequest_bits_last             = outBits.last;
  assign io.vrfWriteRequest_bits_instructionIndex = outBits.instructionIndex;
  assign io.grant_idx                             = grantIdx;

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// Directed and scoreboarded checks of the VRF write arbiter.
// Latency: expects each beat on the output one cycle after it fires.
// Backpressure: exercises VRF stalls, drain-and-refill and reset with a held beat.
module tb_lane_vrf_write_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  lane_vrf_write_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) io ();

  lane_vrf_write_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Beat layout: {vd[5], offset[2], mask[4], data[32], last[1], instructionIndex[3]}.
  function automatic logic [46:0] beat(input int i, input int s);
    beat = {5'(i * 7 + s), 2'(s), 4'(s ^ i), 8'(i), 8'h5A, 16'(s), 1'(s & 1), 3'(i + s)};
  endfunction

  function automatic logic [46:0] outBeat();
    outBeat = {io.vrfWriteRequest_bits_vd, io.vrfWriteRequest_bits_offset,
               io.vrfWriteRequest_bits_mask, io.vrfWriteRequest_bits_data,
               io.vrfWriteRequest_bits_last, io.vrfWriteRequest_bits_instructionIndex};
  endfunction

  task automatic setBits(input int i, input logic [46:0] b);
    io.req_bits_vd[5*i +: 5]               = b[46:42];
    io.req_bits_offset[2*i +: 2]           = b[41:40];
    io.req_bits_mask[4*i +: 4]             = b[39:36];
    io.req_bits_data[32*i +: 32]           = b[35:4];
    io.req_bits_last[i]                    = b[3];
    io.req_bits_instructionIndex[3*i +: 3] = b[2:0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    io.req_valid = '0;
    io.vrfWriteRequest_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io.req_valid = 4'hF;
    io.vrfWriteRequest_ready = 1'b1;
    for (int i = 0; i < 4; i++) setBits(i, beat(i, 1));
    tick();
    #1;
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", io.vrfWriteRequest_valid);
    end
    checks++;
    if (io.grant_idx !== 2'd0) begin
      errors++; $display("FAIL reset_grant: got %0d expected 0", io.grant_idx);
    end
    checks++;
    if (outBeat() !== 47'd0) begin
      errors++; $display("FAIL reset_bits: got %h expected 0", outBeat());
    end
    checks++;
    if (io.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0000", io.req_ready);
    end
    io.req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [46:0] b;
    doReset();
    b = {5'd3, 2'd1, 4'hF, 32'hDEAD_BEEF, 1'b1, 3'd5};
    setBits(0, b);
    io.req_valid = 4'b0001;
    io.vrfWriteRequest_ready = 1'b1;
    #1;
    checks++;
    if (io.req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b expected 0001", io.req_ready);
    end
    tick();
    io.req_valid = 4'b0000;
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b1 || io.vrfWriteRequest_bits_vd !== 5'd3 ||
        io.vrfWriteRequest_bits_data !== 32'hDEAD_BEEF || io.grant_idx !== 2'd0) begin
      errors++; $display("FAIL single_out: got v=%b vd=%0d data=%h g=%0d expected v=1 vd=3 data=deadbeef g=0",
                         io.vrfWriteRequest_valid, io.vrfWriteRequest_bits_vd,
                         io.vrfWriteRequest_bits_data, io.grant_idx);
    end
    checks++;
    if (outBeat() !== b) begin
      errors++; $display("FAIL single_passthrough: got %h expected %h", outBeat(), b);
    end
    tick();
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got %b expected 0", io.vrfWriteRequest_valid);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    doReset();
    for (int i = 0; i < 4; i++) setBits(i, beat(i, 0));
    io.req_valid = 4'hF;
    io.vrfWriteRequest_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      e = c % 4;
      #1;
      checks++;
      if (io.req_ready !== 4'(1 << e)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, io.req_ready, 4'(1 << e));
      end
      tick();
      checks++;
      if (io.vrfWriteRequest_valid !== 1'b1 || io.grant_idx !== 2'(e) || outBeat() !== beat(e, 0)) begin
        errors++; $display("FAIL b2b_out[%0d]: got v=%b g=%0d bits=%h expected v=1 g=%0d bits=%h",
                           c, io.vrfWriteRequest_valid, io.grant_idx, outBeat(), e, beat(e, 0));
      end
    end
    io.req_valid = '0;
  endtask

  task automatic test_stall();
    doReset();
    io.vrfWriteRequest_ready = 1'b1;
    setBits(2, beat(2, 4));
    io.req_valid = 4'b0100;
    #1;
    checks++;
    if (io.req_ready !== 4'b0100) begin
      errors++; $display("FAIL stall_load_ready: got %b expected 0100", io.req_ready);
    end
    tick();
    // Source 2's bus changes after firing; the held beat must not follow it.
    setBits(2, beat(2, 9));
    setBits(1, beat(1, 6));
    io.req_valid = 4'b0010;
    io.vrfWriteRequest_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (io.req_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, io.req_ready);
      end
      checks++;
      if (io.vrfWriteRequest_valid !== 1'b1 || io.grant_idx !== 2'd2 || outBeat() !== beat(2, 4)) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b g=%0d bits=%h expected v=1 g=2 bits=%h",
                           c, io.vrfWriteRequest_valid, io.grant_idx, outBeat(), beat(2, 4));
      end
      tick();
    end
    io.vrfWriteRequest_ready = 1'b1;
    #1;
    checks++;
    if (io.req_ready !== 4'b0010) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 0010", io.req_ready);
    end
    tick();
    io.req_valid = '0;
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b1 || io.grant_idx !== 2'd1 || outBeat() !== beat(1, 6)) begin
      errors++; $display("FAIL stall_next: got v=%b g=%0d bits=%h expected v=1 g=1 bits=%h",
                         io.vrfWriteRequest_valid, io.grant_idx, outBeat(), beat(1, 6));
    end
  endtask

  task automatic test_wrap();
    doReset();
    io.vrfWriteRequest_ready = 1'b1;
    for (int i = 0; i < 4; i++) setBits(i, beat(i, 2));
    io.req_valid = 4'b0100;
    tick();
    io.req_valid = 4'b1001;
    #1;
    checks++;
    if (io.req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_ready3: got %b expected 1000", io.req_ready);
    end
    tick();
    checks++;
    if (io.grant_idx !== 2'd3 || outBeat() !== beat(3, 2)) begin
      errors++; $display("FAIL wrap_grant3: got g=%0d bits=%h expected g=3 bits=%h", io.grant_idx, outBeat(), beat(3, 2));
    end
    checks++;
    if (io.req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_ready0: got %b expected 0001", io.req_ready);
    end
    tick();
    io.req_valid = '0;
    checks++;
    if (io.grant_idx !== 2'd0 || outBeat() !== beat(0, 2)) begin
      errors++; $display("FAIL wrap_grant0: got g=%0d bits=%h expected g=0 bits=%h", io.grant_idx, outBeat(), beat(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    setBits(1, beat(1, 3));
    io.req_valid = 4'b0010;
    tick();
    io.req_valid = '0;
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b1 || io.grant_idx !== 2'd1) begin
      errors++; $display("FAIL midreset_held: got v=%b g=%0d expected v=1 g=1", io.vrfWriteRequest_valid, io.grant_idx);
    end
    reset = 1'b1;
    io.req_valid = 4'hF;
    io.vrfWriteRequest_ready = 1'b1;
    #1;
    checks++;
    if (io.req_ready !== 4'b0000) begin
      errors++; $display("FAIL midreset_ready: got %b expected 0000", io.req_ready);
    end
    tick();
    reset = 1'b0;
    io.req_valid = '0;
    checks++;
    if (io.vrfWriteRequest_valid !== 1'b0 || io.grant_idx !== 2'd0 || outBeat() !== 47'd0) begin
      errors++; $display("FAIL midreset_clear: got v=%b g=%0d bits=%h expected v=0 g=0 bits=0",
                         io.vrfWriteRequest_valid, io.grant_idx, outBeat());
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (io.vrfWriteRequest_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_ghost[%0d]: got %b expected 0", c, io.vrfWriteRequest_valid);
      end
    end
    io.req_valid = 4'hF;
    #1;
    checks++;
    if (io.req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_ptr: got %b expected 0001", io.req_ready);
    end
    io.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [46:0] expQ[$];
    logic [46:0] e;
    int          seq[4];
    int          waitF[4];
    logic [3:0]  vSh;
    logic [3:0]  rdyObs;
    doReset();
    vSh = '0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      waitF[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vSh[i]) vSh[i] = ($urandom_range(0, 1) == 1);
        setBits(i, beat(i, seq[i]));
      end
      io.req_valid = vSh;
      io.vrfWriteRequest_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdyObs = io.req_ready;
      checks++;
      if ($countones(rdyObs) > 1) begin
        errors++; $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", cyc, rdyObs);
      end
      if (io.vrfWriteRequest_valid && io.vrfWriteRequest_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL rnd_extra[%0d]: got beat %h expected none", cyc, outBeat());
        end else begin
          e = expQ.pop_front();
          if (outBeat() !== e) begin
            errors++; $display("FAIL rnd_beat[%0d]: got %h expected %h", cyc, outBeat(), e);
          end
        end
      end
      if (|(vSh & rdyObs)) begin
        for (int i = 0; i < 4; i++) begin
          if (vSh[i] && rdyObs[i]) begin
            checks++;
            if (waitF[i] > 3) begin
              errors++; $display("FAIL rnd_fair[%0d]: req %0d waited %0d fires expected at most 3", cyc, i, waitF[i]);
            end
            waitF[i] = 0;
            expQ.push_back(beat(i, seq[i]));
            seq[i]++;
            vSh[i] = 1'b0;
          end else if (vSh[i]) begin
            waitF[i]++;
          end
        end
      end
      tick();
    end
    io.req_valid = '0;
    io.vrfWriteRequest_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (io.vrfWriteRequest_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL rnd_drain_extra: got beat %h expected none", outBeat());
        end else begin
          e = expQ.pop_front();
          if (outBeat() !== e) begin
            errors++; $display("FAIL rnd_drain_beat: got %h expected %h", outBeat(), e);
          end
        end
      end
      tick();
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL rnd_lost: got %0d beats undelivered expected 0", expQ.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    io.req_valid = '0;
    io.vrfWriteRequest_ready = 1'b0;
    io.req_bits_vd = '0;
    io.req_bits_offset = '0;
    io.req_bits_mask = '0;
    io.req_bits_data = '0;
    io.req_bits_last = '0;
    io.req_bits_instructionIndex = '0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
